idli_sqi_ctrl_m: RTL and testbench
==================================

# idli_sqi_ctrl_m

Sequencer and arbiter for the core's SQI memory pair (hi device holds bits 15:8 of each word, lo device holds bits 7:0). Accepts single-word requests from instruction fetch and load/store, and arbitrates between them round-robin. Runs each granted request as one SQI transaction with these phases: command, address, dummy (reads only), then data. Drives `o_top_sck`/`o_top_cs`/`o_top_sio` and samples `i_top_sio` through idli_top_m.

## Interface
- DUMMY_CYCLES, 2, read dummy nibble cycles between address and data; legal range 1-7.
- i_sqi_gck  in  1  clock.
- i_sqi_rst  in  1  reset, synchronous, active-high.
- i_sqi_fetch_req  in  1  fetch read request; held until granted.
- i_sqi_fetch_addr  in  16  fetch word address.
- o_sqi_fetch_gnt  out  1  request captured this cycle.
- o_sqi_fetch_rvalid  out  1  one-cycle pulse; o_sqi_rdata is valid.
- i_sqi_lsu_req  in  1  LSU request; held until granted.
- i_sqi_lsu_we  in  1  1 = write, 0 = read.
- i_sqi_lsu_addr  in  16  LSU word address.
- i_sqi_lsu_wdata  in  16  write data.
- o_sqi_lsu_gnt  out  1  request captured this cycle.
- o_sqi_lsu_rvalid  out  1  one-cycle pulse; read data valid.
- o_sqi_lsu_wdone  out  1  one-cycle pulse; write complete.
- o_sqi_rdata  out  16  shared read data.
- o_sqi_sck  out  2  {hi,lo} serial clock enables.
- o_sqi_cs  out  2  {hi,lo} chip selects, active-low.
- i_sqi_sio  in  8  {hi,lo} sqi_data_t inputs.
- o_sqi_sio  out  8  {hi,lo} sqi_data_t outputs.
- o_sqi_sio_oe  out  1  1 = controller drives SIO.

## Operation
- States: IDLE, CMD, ADDR, DUMMY, DATA, DONE. A 3-bit phase counter tracks progress within each state.
- **Arbitration** (IDLE or DONE):
  - If exactly one request is pending, grant it.
  - If both are pending, grant the requester that was not granted last.
  - The last-granted pointer resets to "LSU", so fetch wins the first tie.
  - The gnt output is combinational in the accepting cycle. Address, we and wdata are captured on that edge. The requester may deassert req the cycle after gnt.
- **CMD**: 2 nibbles, MS nibble first, identical on both devices. Read command is 8'h03, write command is 8'h02.
- **ADDR**: 6 nibbles of byte address {8'h00, addr}, MS nibble first, identical on both devices.
- **DUMMY** (reads only): DUMMY_CYCLES cycles, o_sqi_sio_oe=0.
- **DATA**: 2 cycles.
  - Write: hi device gets wdata[15:12] then [11:8]; lo device gets [7:4] then [3:0].
  - Read: the same nibble mapping is sampled from i_sqi_sio into o_sqi_rdata; oe=0.
- **DONE**: 1 cycle, cs=2'b11, sck=0.
  - Pulses the owner's rvalid (read) or o_sqi_lsu_wdone (write).
  - If a request is pending, it is granted in DONE and the next state is CMD. Otherwise the next state is IDLE.
- In CMD, ADDR, DUMMY and DATA: cs=2'b00, sck=2'b11. oe=1 except in DUMMY and read DATA.
- o_sqi_rdata holds its value until the next read's DATA phase.

## Timing
- **Reset values**: state IDLE, cs=2'b11, sck=0, sio=0, oe=0, all gnt/rvalid/wdone=0, rdata=0.
- **Read**, with gnt in cycle N and DUMMY_CYCLES=2:
  - CMD in N+1..N+2, ADDR in N+3..N+8, DUMMY in N+9..N+10, DATA in N+11..N+12.
  - DONE with rvalid in N+13.
- **Write**, with gnt in cycle N:
  - CMD in N+1..N+2, ADDR in N+3..N+8, DATA in N+9..N+10.
  - DONE with wdone in N+11.
- **Back-to-back**: cs is high for exactly 1 cycle (DONE) between transactions.
- **Req dropped before gnt**: nothing happens and the pointer is unchanged.
- **Req already high during DONE**: it is granted in that DONE cycle.
- **Reset mid-transaction**: the next cycle is IDLE with cs high. No rvalid/wdone is issued and the in-flight request is discarded. The pointer returns to "LSU".

## Structure
- Shared package idli_pkg holds:
  - sqi_data_t (already present);
  - sqi_state_t enum;
  - SQI_CMD_READ and SQI_CMD_WRITE;
  - SQI_CMD_NIBBLES=2, SQI_ADDR_NIBBLES=6, SQI_DATA_NIBBLES=2.
- One sub-module, idli_sqi_rr_arb_m: 2-way round-robin arbiter with inputs req[1:0] and accept, outputs one-hot gnt[1:0], and the pointer update.
- Shift/nibble-select logic stays in the top module.

## Test plan
- Fetch read, addr 16'h1234, memory model word 16'hBEEF:
  - CS low for 12 cycles.
  - SIO sequence 0,3,0,0,1,2,3,4 on both devices.
  - o_sqi_fetch_rvalid at N+13 with rdata 16'hBEEF.
- LSU write, addr 16'hFFFF, wdata 16'hA55A:
  - Command nibbles 0,2; address F,F,F,F after the 0,0 nibbles.
  - hi device data A,5; lo device data 5,A.
  - wdone at N+11; model stores 16'hA55A.
- Both requesting from reset: fetch granted first, then LSU granted in fetch's DONE cycle, with cs high for exactly 1 cycle between them.
- Fetch held continuously while LSU pulses each grant: grants alternate fetch/LSU, and neither starves.
- Reset asserted in ADDR phase: cs=2'b11 next cycle, no rvalid, and the next request starts a clean CMD.
- DUMMY_CYCLES=4 build: read rvalid at N+15, and oe=0 in N+9..N+14.

Source files
------------

// File: rtl/idli_pkg.sv
// Shared types and constants for the idli core's SQI memory sequencer.
package idli_pkg;

  typedef logic [3:0] sqi_data_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_DUMMY = 3'd3,
    ST_DATA  = 3'd4,
    ST_DONE  = 3'd5
  } sqi_state_t;

  localparam logic [7:0] SQI_CMD_READ  = 8'h03;
  localparam logic [7:0] SQI_CMD_WRITE = 8'h02;

  localparam int SQI_CMD_NIBBLES  = 2;
  localparam int SQI_ADDR_NIBBLES = 6;
  localparam int SQI_DATA_NIBBLES = 2;

  // Nibble idx of a 24-bit byte address, counted from the MS nibble.
  function automatic sqi_data_t sqi_addr_nibble(input logic [23:0] baddr, input logic [2:0] idx);
    sqi_data_t nib;
    case (idx)
      3'd0:    nib = baddr[23:20];
      3'd1:    nib = baddr[19:16];
      3'd2:    nib = baddr[15:12];
      3'd3:    nib = baddr[11:8];
      3'd4:    nib = baddr[7:4];
      3'd5:    nib = baddr[3:0];
      default: nib = 4'h0;
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/idli_sqi_ctrl_m_rr_arb.sv
// Two-way round-robin arbiter; req[0] is fetch, req[1] is LSU.
module idli_sqi_rr_arb_m (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic last_lsu;

  // Lone requester wins; on a tie the side not granted last wins.
  always_comb begin
    gnt = 2'b00;
    if (accept) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_lsu ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end else begin
      gnt = 2'b00;
    end
  end

  // Pointer resets to LSU so fetch wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_lsu <= 1'b1;
    end else if (gnt != 2'b00) begin
      last_lsu <= gnt[1];
    end else begin
      last_lsu <= last_lsu;
    end
  end

endmodule

// File: rtl/idli_sqi_ctrl_m.sv
// SQI transaction sequencer for the hi/lo memory pair, shared by fetch and LSU.
module idli_sqi_ctrl_m #(
  parameter int DUMMY_CYCLES = 2
) (
  input  logic        i_sqi_gck,
  input  logic        i_sqi_rst,
  input  logic        i_sqi_fetch_req,
  input  logic [15:0] i_sqi_fetch_addr,
  output logic        o_sqi_fetch_gnt,
  output logic        o_sqi_fetch_rvalid,
  input  logic        i_sqi_lsu_req,
  input  logic        i_sqi_lsu_we,
  input  logic [15:0] i_sqi_lsu_addr,
  input  logic [15:0] i_sqi_lsu_wdata,
  output logic        o_sqi_lsu_gnt,
  output logic        o_sqi_lsu_rvalid,
  output logic        o_sqi_lsu_wdone,
  output logic [15:0] o_sqi_rdata,
  output logic [1:0]  o_sqi_sck,
  output logic [1:0]  o_sqi_cs,
  input  logic [7:0]  i_sqi_sio,
  output logic [7:0]  o_sqi_sio,
  output logic        o_sqi_sio_oe
);

  import idli_pkg::*;

  localparam logic [2:0] CMD_LAST   = 3'(SQI_CMD_NIBBLES - 1);
  localparam logic [2:0] ADDR_LAST  = 3'(SQI_ADDR_NIBBLES - 1);
  localparam logic [2:0] DUMMY_LAST = 3'(DUMMY_CYCLES - 1);
  localparam logic [2:0] DATA_LAST  = 3'(SQI_DATA_NIBBLES - 1);

  sqi_state_t  state;
  sqi_state_t  state_nxt;
  logic [2:0]  phase;
  logic [1:0]  gnt;
  logic        accept;
  logic        owner_lsu;
  logic        cur_we;
  logic [15:0] cur_addr;
  logic [15:0] cur_wdata;
  logic [15:0] rdata;
  logic [7:0]  cmd;
  sqi_data_t   nib;

  // No grant while reset is held, so nothing is handed out and then dropped.
  assign accept = ((state == ST_IDLE) || (state == ST_DONE)) && !i_sqi_rst;

  idli_sqi_rr_arb_m u_arb (
    .clk    (i_sqi_gck),
    .rst    (i_sqi_rst),
    .req    ({i_sqi_lsu_req, i_sqi_fetch_req}),
    .accept (accept),
    .gnt    (gnt)
  );

  assign o_sqi_fetch_gnt = gnt[0];
  assign o_sqi_lsu_gnt   = gnt[1];
  assign o_sqi_rdata     = rdata;
  assign cmd             = cur_we ? SQI_CMD_WRITE : SQI_CMD_READ;

  // State register; phase restarts on every state change.
  always_ff @(posedge i_sqi_gck) begin
    if (i_sqi_rst) begin
      state <= ST_IDLE;
      phase <= 3'd0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        phase <= 3'd0;
      end else begin
        phase <= phase + 3'd1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = (gnt != 2'b00) ? ST_CMD : ST_IDLE;
      ST_CMD:   state_nxt = (phase == CMD_LAST) ? ST_ADDR : ST_CMD;
      ST_ADDR: begin
        if (phase == ADDR_LAST) begin
          state_nxt = cur_we ? ST_DATA : ST_DUMMY;
        end else begin
          state_nxt = ST_ADDR;
        end
      end
      ST_DUMMY: state_nxt = (phase == DUMMY_LAST) ? ST_DATA : ST_DUMMY;
      ST_DATA:  state_nxt = (phase == DATA_LAST) ? ST_DONE : ST_DATA;
      ST_DONE:  state_nxt = (gnt != 2'b00) ? ST_CMD : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Capture the granted request on the grant edge.
  always_ff @(posedge i_sqi_gck) begin
    if (i_sqi_rst) begin
      owner_lsu <= 1'b0;
      cur_we    <= 1'b0;
      cur_addr  <= 16'h0000;
      cur_wdata <= 16'h0000;
    end else if (gnt != 2'b00) begin
      owner_lsu <= gnt[1];
      cur_we    <= gnt[1] & i_sqi_lsu_we;
      cur_addr  <= gnt[1] ? i_sqi_lsu_addr : i_sqi_fetch_addr;
      cur_wdata <= i_sqi_lsu_wdata;
    end else begin
      owner_lsu <= owner_lsu;
      cur_we    <= cur_we;
      cur_addr  <= cur_addr;
      cur_wdata <= cur_wdata;
    end
  end

  // Read data: hi device supplies byte 15:8, lo device byte 7:0, MS nibble first.
  always_ff @(posedge i_sqi_gck) begin
    if (i_sqi_rst) begin
      rdata <= 16'h0000;
    end else if ((state == ST_DATA) && !cur_we) begin
      if (phase[0] == 1'b0) begin
        rdata[15:12] <= i_sqi_sio[7:4];
        rdata[7:4]   <= i_sqi_sio[3:0];
      end else begin
        rdata[11:8]  <= i_sqi_sio[7:4];
        rdata[3:0]   <= i_sqi_sio[3:0];
      end
    end else begin
      rdata <= rdata;
    end
  end

  // Pin and handshake decode from the registered state.
  always_comb begin
    o_sqi_cs           = 2'b11;
    o_sqi_sck          = 2'b00;
    o_sqi_sio          = 8'h00;
    o_sqi_sio_oe       = 1'b0;
    o_sqi_fetch_rvalid = 1'b0;
    o_sqi_lsu_rvalid   = 1'b0;
    o_sqi_lsu_wdone    = 1'b0;
    nib                = 4'h0;
    case (state)
      ST_CMD: begin
        o_sqi_cs     = 2'b00;
        o_sqi_sck    = 2'b11;
        o_sqi_sio_oe = 1'b1;
        nib          = phase[0] ? cmd[3:0] : cmd[7:4];
        o_sqi_sio    = {nib, nib};
      end
      ST_ADDR: begin
        o_sqi_cs     = 2'b00;
        o_sqi_sck    = 2'b11;
        o_sqi_sio_oe = 1'b1;
        nib          = sqi_addr_nibble({8'h00, cur_addr}, phase);
        o_sqi_sio    = {nib, nib};
      end
      ST_DUMMY: begin
        o_sqi_cs  = 2'b00;
        o_sqi_sck = 2'b11;
      end
      ST_DATA: begin
        o_sqi_cs  = 2'b00;
        o_sqi_sck = 2'b11;
        if (cur_we) begin
          o_sqi_sio_oe = 1'b1;
          o_sqi_sio    = phase[0] ? {cur_wdata[11:8], cur_wdata[3:0]}
                                  : {cur_wdata[15:12], cur_wdata[7:4]};
        end else begin
          o_sqi_sio_oe = 1'b0;
        end
      end
      ST_DONE: begin
        o_sqi_fetch_rvalid = !owner_lsu;
        o_sqi_lsu_rvalid   = owner_lsu & !cur_we;
        o_sqi_lsu_wdone    = owner_lsu & cur_we;
      end
      default: begin
        o_sqi_cs = 2'b11;
      end
    endcase
  end

endmodule

// File: tb/tb_idli_sqi_ctrl_m.sv
// Scoreboard bench: two controllers (2 and 4 dummy cycles) each talking to a pin-level SQI memory model.
`timescale 1ns/1ps
module tb_idli_sqi_ctrl_m;

  typedef struct {
    int          kind;   // 0 fetch read, 1 lsu read, 2 lsu write
    logic [15:0] addr;
    logic [15:0] data;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        exp_q [2][$];
  int          gnt_log [$];
  logic [15:0] ref_w [int];

  logic        fetch_req [2];
  logic [15:0] fetch_addr [2];
  logic        lsu_req [2];
  logic        lsu_we [2];
  logic [15:0] lsu_addr [2];
  logic [15:0] lsu_wdata [2];
  logic        fetch_gnt [2];
  logic        fetch_rvalid [2];
  logic        lsu_gnt [2];
  logic        lsu_rvalid [2];
  logic        lsu_wdone [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] init_word(input logic [15:0] a);
    if (a == 16'h1234) return 16'hBEEF;
    return a ^ 16'h5A5A;
  endfunction

  function automatic int dc_of(input int g);
    return (g == 0) ? 2 : 4;
  endfunction

  function automatic logic [15:0] exp_word(input int g, input logic [15:0] a);
    int key;
    key = g * 65536 + int'(a);
    if (ref_w.exists(key)) return ref_w[key];
    return init_word(a);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic fetch_read(input int g, input logic [15:0] a, output int gc);
    bit   ok;
    exp_t e;
    ok = 1'b0;
    gc = -1;
    fetch_addr[g] = a;
    fetch_req[g]  = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (fetch_gnt[g]) ok = 1'b1;
    end
    if (ok) begin
      gc = cyc;
      e.kind = 0; e.addr = a; e.data = exp_word(g, a); e.due = cyc + 11 + dc_of(g);
      exp_q[g].push_back(e);
      if (g == 0) gnt_log.push_back(0);
    end else begin
      check_eq("fetch_gnt_timeout", 32'd0, 32'd1);
    end
    @(posedge clk);
    #1 fetch_req[g] = 1'b0;
  endtask

  task automatic lsu_op(input int g, input logic we, input logic [15:0] a,
                        input logic [15:0] wd, output int gc);
    bit   ok;
    exp_t e;
    ok = 1'b0;
    gc = -1;
    lsu_we[g]    = we;
    lsu_addr[g]  = a;
    lsu_wdata[g] = wd;
    lsu_req[g]   = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (lsu_gnt[g]) ok = 1'b1;
    end
    if (ok) begin
      gc = cyc;
      e.kind = we ? 2 : 1; e.addr = a; e.data = we ? wd : exp_word(g, a);
      e.due = cyc + (we ? 11 : 11 + dc_of(g));
      exp_q[g].push_back(e);
      if (we) ref_w[g * 65536 + int'(a)] = wd;
      if (g == 0) gnt_log.push_back(1);
    end else begin
      check_eq("lsu_gnt_timeout", 32'd0, 32'd1);
    end
    @(posedge clk);
    #1 lsu_req[g] = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", 32'(exp_q[0].size() + exp_q[1].size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int DCG = (g == 0) ? 2 : 4;
    logic [1:0]  sck;
    logic [1:0]  cs;
    logic [7:0]  sio_out;
    logic [7:0]  sio_in;
    logic        oe;
    logic [15:0] rdata;
    int          s_cnt;
    int          s_sck;
    int          s_oe;
    logic [31:0] s_hdr_hi;
    logic [31:0] s_hdr_lo;
    logic [7:0]  s_dhi;
    logic [7:0]  s_dlo;
    logic [15:0] s_mem [0:65535];
    logic [15:0] s_word;

    idli_sqi_ctrl_m #(.DUMMY_CYCLES(DCG)) u_dut (
      .i_sqi_gck          (clk),
      .i_sqi_rst          (rst),
      .i_sqi_fetch_req    (fetch_req[g]),
      .i_sqi_fetch_addr   (fetch_addr[g]),
      .o_sqi_fetch_gnt    (fetch_gnt[g]),
      .o_sqi_fetch_rvalid (fetch_rvalid[g]),
      .i_sqi_lsu_req      (lsu_req[g]),
      .i_sqi_lsu_we       (lsu_we[g]),
      .i_sqi_lsu_addr     (lsu_addr[g]),
      .i_sqi_lsu_wdata    (lsu_wdata[g]),
      .o_sqi_lsu_gnt      (lsu_gnt[g]),
      .o_sqi_lsu_rvalid   (lsu_rvalid[g]),
      .o_sqi_lsu_wdone    (lsu_wdone[g]),
      .o_sqi_rdata        (rdata),
      .o_sqi_sck          (sck),
      .o_sqi_cs           (cs),
      .i_sqi_sio          (sio_in),
      .o_sqi_sio          (sio_out),
      .o_sqi_sio_oe       (oe)
    );

    initial begin
      for (int i = 0; i < 65536; i++) s_mem[i] = init_word(16'(i));
    end

    // Memory pair model: records pins while cs is low, stores write data.
    always @(posedge clk) begin
      if (rst || cs == 2'b11) begin
        s_cnt <= 0;
        s_sck <= 0;
        s_oe  <= 0;
      end else begin
        s_cnt <= s_cnt + 1;
        if (sck == 2'b11) s_sck <= s_sck + 1;
        if (oe) s_oe <= s_oe + 1;
        if (s_cnt < 8) begin
          s_hdr_hi <= {s_hdr_hi[27:0], sio_out[7:4]};
          s_hdr_lo <= {s_hdr_lo[27:0], sio_out[3:0]};
        end else if (s_hdr_hi[31:24] == 8'h02) begin
          s_dhi <= {s_dhi[3:0], sio_out[7:4]};
          s_dlo <= {s_dlo[3:0], sio_out[3:0]};
          if (s_cnt == 9)
            s_mem[s_hdr_hi[15:0]] <= {s_dhi[3:0], sio_out[7:4], s_dlo[3:0], sio_out[3:0]};
        end
      end
    end

    assign s_word = s_mem[s_hdr_hi[15:0]];

    always_comb begin
      sio_in = 8'h00;
      if (cs == 2'b00 && s_hdr_hi[31:24] == 8'h03) begin
        if (s_cnt == 8 + DCG)      sio_in = {s_word[15:12], s_word[7:4]};
        else if (s_cnt == 9 + DCG) sio_in = {s_word[11:8], s_word[3:0]};
      end
    end

    initial begin : mon
      exp_t        e;
      int          k;
      logic [7:0]  cmd;
      forever begin
        @(negedge clk);
        if (!rst) begin
          if (fetch_gnt[g] || lsu_gnt[g])
            check_eq("gnt_onehot", 32'(fetch_gnt[g] & lsu_gnt[g]), 32'd0);
          if (fetch_rvalid[g] || lsu_rvalid[g] || lsu_wdone[g]) begin
            check_eq("one_pulse", 32'(fetch_rvalid[g]) + 32'(lsu_rvalid[g]) + 32'(lsu_wdone[g]), 32'd1);
            k = fetch_rvalid[g] ? 0 : (lsu_rvalid[g] ? 1 : 2);
            if (exp_q[g].size() == 0) begin
              check_eq("unexpected_done", 32'(k), 32'hFFFF);
            end else begin
              e = exp_q[g].pop_front();
              cmd = (e.kind == 2) ? 8'h02 : 8'h03;
              check_eq("done_kind", 32'(k), 32'(e.kind));
              check_eq("done_cycle", 32'(cyc), 32'(e.due));
              check_eq("cs_done", 32'(cs), 32'd3);
              check_eq("cs_low_cycles", 32'(s_cnt), (e.kind == 2) ? 32'd10 : 32'(10 + DCG));
              check_eq("sck_cycles", 32'(s_sck), (e.kind == 2) ? 32'd10 : 32'(10 + DCG));
              check_eq("oe_cycles", 32'(s_oe), (e.kind == 2) ? 32'd10 : 32'd8);
              check_eq("hdr_hi", s_hdr_hi, {cmd, 8'h00, e.addr});
              check_eq("hdr_lo", s_hdr_lo, {cmd, 8'h00, e.addr});
              if (e.kind == 2) begin
                check_eq("wr_hi_nibbles", 32'(s_dhi), 32'({e.data[15:12], e.data[11:8]}));
                check_eq("wr_lo_nibbles", 32'(s_dlo), 32'({e.data[7:4], e.data[3:0]}));
                check_eq("wr_mem", 32'(s_mem[e.addr]), 32'(e.data));
              end else begin
                check_eq("rdata", 32'(rdata), 32'(e.data));
              end
            end
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gc_f, gc_l, gc_x;
    for (int g = 0; g < 2; g++) begin
      fetch_req[g] = 1'b0; fetch_addr[g] = 16'h0000;
      lsu_req[g] = 1'b0; lsu_we[g] = 1'b0; lsu_addr[g] = 16'h0000; lsu_wdata[g] = 16'h0000;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_cs", 32'(g_inst[0].cs), 32'd3);
    check_eq("rst_sck", 32'(g_inst[0].sck), 32'd0);
    check_eq("rst_sio", 32'(g_inst[0].sio_out), 32'd0);
    check_eq("rst_oe", 32'(g_inst[0].oe), 32'd0);
    check_eq("rst_rdata", 32'(g_inst[0].rdata), 32'd0);
    check_eq("rst_valid", 32'({fetch_rvalid[0], lsu_rvalid[0], lsu_wdone[0], fetch_gnt[0]}), 32'd0);
    check_eq("rst_cs_d4", 32'(g_inst[1].cs), 32'd3);
    @(posedge clk);
    #1;

    // Both requesting from reset: fetch first, LSU write granted in fetch's DONE.
    fork
      fetch_read(0, 16'h1234, gc_f);
      lsu_op(0, 1'b1, 16'hFFFF, 16'hA55A, gc_l);
      fetch_read(1, 16'h1234, gc_x);
    join
    check_eq("tie_fetch_first", 32'(gc_l), 32'(gc_f + 13));
    wait_drain();

    lsu_op(0, 1'b0, 16'hFFFF, 16'h0000, gc_l);
    wait_drain();

    // LSU request dropped while busy: no grant, pointer stays on fetch.
    fetch_read(0, 16'h0042, gc_f);
    lsu_addr[0] = 16'h0099; lsu_we[0] = 1'b0; lsu_req[0] = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_eq("busy_nogrant", 32'(lsu_gnt[0]), 32'd0);
    end
    @(posedge clk);
    #1 lsu_req[0] = 1'b0;
    wait_drain();
    fork
      fetch_read(0, 16'h0043, gc_f);
      lsu_op(0, 1'b0, 16'h0044, 16'h0000, gc_l);
    join
    check_eq("ptr_kept_lsu_wins", 32'(gc_f), 32'(gc_l + 13));
    wait_drain();

    // Fetch held continuously while LSU re-requests: grants alternate.
    gnt_log.delete();
    fork
      begin
        for (int i = 0; i < 4; i++) fetch_read(0, 16'h0200 + 16'(i), gc_f);
      end
      begin
        for (int j = 0; j < 4; j++) lsu_op(0, j[0], 16'h0300 + 16'(j), 16'hC000 + 16'(j), gc_l);
      end
    join
    check_eq("alt_count", 32'(gnt_log.size()), 32'd8);
    for (int i = 1; i < gnt_log.size(); i++)
      check_eq("alt_order", 32'(gnt_log[i] != gnt_log[i-1]), 32'd1);
    wait_drain();

    // Reset in ADDR: transaction discarded, pointer back to LSU.
    fetch_read(0, 16'h0777, gc_f);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q[0].delete();
    @(negedge clk);
    check_eq("rst_mid_cs", 32'(g_inst[0].cs), 32'd3);
    check_eq("rst_mid_rvalid", 32'(fetch_rvalid[0]), 32'd0);
    repeat (20) @(negedge clk);
    @(posedge clk);
    #1;
    fork
      fetch_read(0, 16'h0777, gc_f);
      lsu_op(0, 1'b0, 16'h0100, 16'h0000, gc_l);
    join
    check_eq("rst_ptr_fetch_first", 32'(gc_l), 32'(gc_f + 13));
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
